hilo_unit: RTL and testbench

- HI/LO register stage directly downstream of the combinational multiply/divide unit.
- Captures the unit's 64-bit result when a mult/div instruction issues, and holds it pending for a configurable latency that models a multi-cycle multiplier/divider.
- Then commits the result into the architectural HI and LO registers.
- Also serves mthi/mtlo writes and mfhi/mflo reads, raising a pipeline stall while a result is outstanding.

---
 rtl/hilo_unit_pkg.sv | 22 ++
 rtl/hilo_unit_countdown.sv | 42 ++++
 rtl/hilo_unit.sv | 102 ++++++++++
 tb/tb_hilo_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared mul/div op encodings, default latencies and counter sizing helpers
// for the HI/LO register stage.
package hilo_unit_pkg;

  localparam logic [1:0] MD_DIV   = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_MULTU = 2'b11;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 32;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the longest latency value, so size it for max+1 states.
  function automatic int cnt_width(input int mul_lat, input int div_lat);
    return $clog2(lat_max(mul_lat, div_lat) + 1);
  endfunction

endpackage

// File: rtl/hilo_unit_countdown.sv
// Loadable down-counter tracking the remaining latency of an outstanding
// mul/div result; flags busy and the final cycle before commit.
module md_countdown
  import hilo_unit_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO architectural registers fed by the mul/div unit: holds a captured
// result for a modelled latency, then commits; serves mthi/mtlo and stalls.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mdOp,
  input  logic [31:0] mdHi,
  input  logic [31:0] mdLo,
  input  logic        wrHi,
  input  logic        wrLo,
  input  logic [31:0] wdata,
  input  logic        rdHiLo,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int CW = cnt_width(MUL_LAT, DIV_LAT);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  logic          is_mul;
  logic          lat_one;
  logic          accept;
  logic          load;
  logic          last;
  logic [CW-1:0] load_val;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  assign is_mul   = (mdOp == MD_MULT) || (mdOp == MD_MULTU);
  assign lat_one  = is_mul ? (MUL_LAT == 1) : (DIV_LAT == 1);
  assign accept   = start & ~busy & ~flush;
  // Single-cycle ops write HI/LO straight away and never occupy the counter.
  assign load     = accept & ~lat_one;
  assign load_val = is_mul ? MUL_LOAD : DIV_LOAD;

  md_countdown #(
    .W (CW)
  ) u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clear    (flush),
    .load_val (load_val),
    .busy     (busy),
    .last     (last)
  );

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (!flush) begin
      if (last) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end else if (accept) begin
        pend_hi_d = mdHi;
        pend_lo_d = mdLo;
        if (lat_one) begin
          hi_d = mdHi;
          lo_d = mdLo;
        end
      end else if (!busy) begin
        if (wrHi) hi_d = wdata;
        if (wrLo) lo_d = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy & (rdHiLo | start | wrHi | wrLo);

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus a randomized run
// against a cycle-stamped reference model of pending results.
module tb_hilo_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mdOp = 2'b00;
  logic [31:0] mdHi = '0;
  logic [31:0] mdLo = '0;
  logic        wrHi = 1'b0;
  logic        wrLo = 1'b0;
  logic [31:0] wdata = '0;
  logic        rdHiLo = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int checks = 0;
  int errors = 0;

  // Reference model: a pending result is described by the absolute cycle at
  // which it becomes visible, not by a down-counter.
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          m_pend = 0;
  int          m_done = 0;
  logic [31:0] m_phi = '0;
  logic [31:0] m_plo = '0;

  hilo_unit #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mdOp   (mdOp),
    .mdHi   (mdHi),
    .mdLo   (mdLo),
    .wrHi   (wrHi),
    .wrLo   (wrLo),
    .wdata  (wdata),
    .rdHiLo (rdHiLo),
    .flush  (flush),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int lat;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_pend = 0;
    end else if (flush) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (cyc + 1 == m_done) begin
        m_hi = m_phi; m_lo = m_plo; m_pend = 0;
      end
    end else if (start) begin
      lat = mdOp[1] ? MUL_LAT : DIV_LAT;
      if (lat == 1) begin
        m_hi = mdHi; m_lo = mdLo;
      end else begin
        m_pend = 1; m_done = cyc + lat; m_phi = mdHi; m_plo = mdLo;
      end
    end else begin
      if (wrHi) m_hi = wdata;
      if (wrLo) m_lo = wdata;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    start = 0; wrHi = 0; wrLo = 0; rdHiLo = 0; flush = 0; rst = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] h, input logic [31:0] l);
    mdOp = op; mdHi = h; mdLo = l; start = 1;
    step();
    start = 0;
    mdHi = $urandom; mdLo = $urandom;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b stall=%b, want 0/0/0/0", hi, lo, busy, stall);
    end
    $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_mult();
    issue(2'b10, 32'h0000_0001, 32'h2345_6789);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (busy !== 1'b1 || hi !== 32'h0) begin
        errors++;
        $display("FAIL mult_busy c%0d: busy=%b hi=%h, want 1/00000000", i, busy, hi);
      end
      step();
    end
    checks++;
    if (hi !== 32'h0000_0001 || lo !== 32'h2345_6789 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_commit: hi=%h lo=%h busy=%b, want 00000001/23456789/0", hi, lo, busy);
    end
    $display("mult: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_div_stall();
    issue(2'b00, 32'h2, 32'h5);
    rdHiLo = 1;
    for (int i = 1; i <= 31; i++) begin
      #1;
      checks++;
      if (stall !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL div_stall c%0d: stall=%b busy=%b, want 1/1", i, stall, busy);
      end
      step();
    end
    #1;
    checks++;
    if (stall !== 1'b0 || hi !== 32'h2 || lo !== 32'h5) begin
      errors++;
      $display("FAIL div_commit: stall=%b hi=%h lo=%h, want 0/00000002/00000005", stall, hi, lo);
    end
    rdHiLo = 0;
    $display("div: hi=%h lo=%h stall=%b", hi, lo, stall);
  endtask

  task automatic test_mthi();
    wrHi = 1; wdata = 32'hDEAD_BEEF;
    step();
    wrHi = 0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h5) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h, want deadbeef/00000005", hi, lo);
    end
    $display("mthi: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_start_wrlo();
    wrLo = 1; wdata = 32'h0000_FFFF;
    issue(2'b10, 32'h0, 32'h10);
    wrLo = 0;
    checks++;
    if (lo !== 32'h5) begin
      errors++;
      $display("FAIL start_wrlo_discard: lo=%h, want 00000005", lo);
    end
    repeat (4) step();
    checks++;
    if (lo !== 32'h10 || hi !== 32'h0) begin
      errors++;
      $display("FAIL start_wrlo_commit: hi=%h lo=%h, want 00000000/00000010", hi, lo);
    end
    $display("start+wrLo: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_flush(input int flush_cyc);
    issue(2'b11, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    repeat (flush_cyc - 1) step();
    flush = 1;
    step();
    flush = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush%0d_busy: busy=%b, want 0", flush_cyc, busy);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hi !== 32'h0 || lo !== 32'h10) begin
        errors++;
        $display("FAIL flush%0d_hold: hi=%h lo=%h, want 00000000/00000010", flush_cyc, hi, lo);
      end
      step();
    end
    $display("flush@%0d: hi=%h lo=%h busy=%b", flush_cyc, hi, lo, busy);
  endtask

  task automatic test_reset_mid_div();
    wrHi = 1; wrLo = 1; wdata = 32'h1234_5678;
    step();
    wrHi = 0; wrLo = 0;
    issue(2'b01, 32'h7, 32'h8);
    step();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_div: hi=%h lo=%h busy=%b, want 0/0/0", hi, lo, busy);
    end
    repeat (DIV_LAT + 2) step();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL rst_no_commit: hi=%h lo=%h, want 0/0", hi, lo);
    end
    $display("rst mid-div: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_random();
    bit exp_stall;
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      mdOp   = 2'($urandom_range(0, 3));
      mdHi   = $urandom;
      mdLo   = $urandom;
      wrHi   = ($urandom_range(0, 5) == 0);
      wrLo   = ($urandom_range(0, 5) == 0);
      wdata  = $urandom;
      rdHiLo = ($urandom_range(0, 2) == 0);
      flush  = ($urandom_range(0, 40) == 0);
      rst    = ($urandom_range(0, 150) == 0);
      #1;
      exp_stall = m_pend & (rdHiLo | start | wrHi | wrLo);
      checks++;
      if (hi !== m_hi || lo !== m_lo || busy !== m_pend || stall !== exp_stall) begin
        errors++;
        bad++;
        $display("FAIL random c%0d: hi=%h lo=%h busy=%b stall=%b, want %h/%h/%b/%b",
                 i, hi, lo, busy, stall, m_hi, m_lo, m_pend, exp_stall);
      end
      step();
    end
    idle_inputs();
    $display("random: 1500 cycles, %0d bad", bad);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_stall();
    test_mthi();
    test_start_wrlo();
    test_flush(3);
    test_flush(4);
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
